// File: rtl/frodo_pkg.sv
// Shared FrodoKEM definitions: parameter-set encodings, lane geometry and the
// modulus mask.
package frodo_pkg;

  localparam int LANE_W    = 16;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    MODE_640  = 2'b00,
    MODE_976  = 2'b01,
    MODE_1344 = 2'b10
  } mode_e;

  // q = 2^15 only for Frodo-640; every other code (including reserved) is 2^16.
  function automatic logic [LANE_W-1:0] q_mask(input logic [1:0] mode);
    return (mode == MODE_640) ? 16'h7FFF : 16'hFFFF;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: stage-1 product/addend registers, then a stage-2 add, mask and
// accumulator.
module mac_lane
  import frodo_pkg::*;
#(
  parameter int W = LANE_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_valid,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  input  logic         i_s2_valid,
  input  logic         i_s2_acc_en,
  input  logic         i_s2_acc_clr,
  input  logic [W-1:0] i_s2_mask,
  output logic [W-1:0] o_data
);

  logic [W-1:0] w_prod;
  logic [W-1:0] w_addend;
  logic [W-1:0] w_result;
  logic [W-1:0] r_prod;
  logic [W-1:0] r_c;
  logic [W-1:0] r_acc;
  logic [W-1:0] r_data;

  // Truncating to W bits is exact because q divides 2^W.
  assign w_prod = i_a * i_b;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prod <= '0;
      r_c    <= '0;
    end else if (i_valid) begin
      r_prod <= w_prod;
      r_c    <= i_c;
    end
  end

  always_comb begin
    w_addend = r_c;
    if (i_s2_acc_en) begin
      w_addend = i_s2_acc_clr ? '0 : r_acc;
    end
    w_result = (r_prod + w_addend) & i_s2_mask;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data <= '0;
      r_acc  <= '0;
    end else if (i_s2_valid) begin
      r_data <= w_result;
      if (i_s2_acc_en) begin
        r_acc <= w_result;
      end
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/mac_array.sv
// Four-lane modular multiply-accumulate with a fixed two-cycle pipeline; the
// valid/control pipeline is shared and each lane holds its own datapath.
module mac_array
  import frodo_pkg::*;
#(
  parameter int LANES = NUM_LANES,
  parameter int W     = LANE_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [1:0]         mode,
  input  logic               in_valid,
  input  logic               acc_en,
  input  logic               acc_clr,
  input  logic [W-1:0]       mac_A,
  input  logic [LANES*W-1:0] mac_B,
  input  logic [LANES*W-1:0] mac_C,
  output logic               out_valid,
  output logic [W-1:0]       mac_data_0,
  output logic [W-1:0]       mac_data_1,
  output logic [W-1:0]       mac_data_2,
  output logic [W-1:0]       mac_data_3
);

  logic         r_s1_valid;
  logic         r_s1_acc_en;
  logic         r_s1_acc_clr;
  logic [W-1:0] r_s1_mask;
  logic         r_out_valid;
  logic [W-1:0] w_lane_data [LANES];

  // Mode travels with the beat so a mode change only affects later beats.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_valid   <= 1'b0;
      r_s1_acc_en  <= 1'b0;
      r_s1_acc_clr <= 1'b0;
      r_s1_mask    <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      r_s1_valid   <= in_valid;
      r_s1_acc_en  <= acc_en;
      r_s1_acc_clr <= acc_clr;
      r_s1_mask    <= q_mask(mode);
      r_out_valid  <= r_s1_valid;
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      mac_lane #(.W(W)) u_lane (
        .clk          (clk),
        .rstn         (rstn),
        .i_valid      (in_valid),
        .i_a          (mac_A),
        .i_b          (mac_B[gi*W +: W]),
        .i_c          (mac_C[gi*W +: W]),
        .i_s2_valid   (r_s1_valid),
        .i_s2_acc_en  (r_s1_acc_en),
        .i_s2_acc_clr (r_s1_acc_clr),
        .i_s2_mask    (r_s1_mask),
        .o_data       (w_lane_data[gi])
      );
    end
  endgenerate

  assign out_valid  = r_out_valid;
  assign mac_data_0 = w_lane_data[0];
  assign mac_data_1 = w_lane_data[1];
  assign mac_data_2 = w_lane_data[2];
  assign mac_data_3 = w_lane_data[3];

endmodule

// File: tb/tb_mac_array.sv
// Self-checking bench for mac_array: directed cases plus a random soak against
// a queue-based arithmetic reference model.
module tb_mac_array;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  mode;
  logic        in_valid;
  logic        acc_en;
  logic        acc_clr;
  logic [15:0] mac_A;
  logic [63:0] mac_B;
  logic [63:0] mac_C;
  logic        out_valid;
  logic [15:0] mac_data_0;
  logic [15:0] mac_data_1;
  logic [15:0] mac_data_2;
  logic [15:0] mac_data_3;

  mac_array dut (
    .clk        (clk),
    .rstn       (rstn),
    .mode       (mode),
    .in_valid   (in_valid),
    .acc_en     (acc_en),
    .acc_clr    (acc_clr),
    .mac_A      (mac_A),
    .mac_B      (mac_B),
    .mac_C      (mac_C),
    .out_valid  (out_valid),
    .mac_data_0 (mac_data_0),
    .mac_data_1 (mac_data_1),
    .mac_data_2 (mac_data_2),
    .mac_data_3 (mac_data_3)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] acc_m [4];
  logic [63:0] last_exp = '0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cycle    = 0;
  int          n_in     = 0;
  int          n_out    = 0;
  bit          chk_v;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // r = (A*B + addend) mod q, computed with wide integer arithmetic.
  function automatic logic [15:0] ref_lane(input logic [1:0] m, input logic [15:0] a,
                                           input logic [15:0] b, input logic [15:0] addend);
    longint unsigned q;
    longint unsigned v;
    q = (m == 2'b00) ? 64'd32768 : 64'd65536;
    v = 64'(a) * 64'(b) + 64'(addend);
    return 16'(v % q);
  endfunction

  task automatic send(input logic [1:0] m, input logic en, input logic clr,
                      input logic [15:0] a, input logic [63:0] b, input logic [63:0] c);
    exp_t        e;
    logic [15:0] addend;
    logic [15:0] r;
    @(posedge clk);
    #1;
    mode = m; in_valid = 1'b1; acc_en = en; acc_clr = clr;
    mac_A = a; mac_B = b; mac_C = c;
    e.due  = cycle + 2;
    e.data = '0;
    for (int i = 0; i < 4; i++) begin
      if (!en) addend = c[16*i +: 16];
      else if (clr) addend = 16'h0;
      else addend = acc_m[i];
      r = ref_lane(m, a, b[16*i +: 16], addend);
      if (en) acc_m[i] = r;
      e.data[16*i +: 16] = r;
    end
    exp_q.push_back(e);
    n_in++;
    $display("beat cyc=%0d mode=%0d en=%0b clr=%0b A=%h B=%h C=%h exp=%h",
             cycle, m, en, clr, a, b, c, e.data);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      acc_en   = 1'($urandom);
      acc_clr  = 1'($urandom);
      mac_A    = 16'($urandom);
      mac_B    = {$urandom, $urandom};
      mac_C    = {$urandom, $urandom};
    end
  endtask

  task automatic expect_lanes(input string tag, input logic [63:0] exp);
    @(negedge clk);
    #1;
    check_val(tag, {mac_data_3, mac_data_2, mac_data_1, mac_data_0}, exp);
  endtask

  // Per-cycle scoreboard: valid timing, data on valid cycles, hold otherwise.
  always @(negedge clk) begin
    chk_v = (exp_q.size() > 0) && (exp_q[0].due <= cycle);
    check_val("out_valid", {63'b0, out_valid}, {63'b0, chk_v});
    if (out_valid) n_out++;
    if (chk_v) begin
      last_exp = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    check_val(out_valid ? "data" : "hold",
              {mac_data_3, mac_data_2, mac_data_1, mac_data_0}, last_exp);
  end

  initial begin
    rstn = 1'b0; mode = 2'b00; in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    mac_A = '0; mac_B = '0; mac_C = '0;
    for (int i = 0; i < 4; i++) acc_m[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_valid", {63'b0, out_valid}, 64'h0);
    check_val("reset_data", {mac_data_3, mac_data_2, mac_data_1, mac_data_0}, 64'h0);
    rstn = 1'b1;

    // Basic, 640
    send(2'b00, 1'b0, 1'b0, 16'd3, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd40, 16'd30, 16'd20, 16'd10});
    idle(3);
    expect_lanes("basic_640", {16'd52, 16'd39, 16'd26, 16'd13});

    // Wrap cases, 640 vs 976
    send(2'b00, 1'b0, 1'b0, 16'h8001, 64'h3, 64'h7FFF);
    idle(3);
    expect_lanes("wrap_640", 64'h0002);
    send(2'b01, 1'b0, 1'b0, 16'h8001, 64'h3, 64'h7FFF);
    idle(3);
    expect_lanes("wrap_976", 64'h0002);
    send(2'b00, 1'b0, 1'b0, 16'h0001, 64'h8000, 64'h0);
    idle(3);
    expect_lanes("bit15_640", 64'h0000);
    send(2'b01, 1'b0, 1'b0, 16'h0001, 64'h8000, 64'h0);
    idle(3);
    expect_lanes("bit15_976", 64'h8000);

    // Accumulate chain: 10, 17, 24, 31 back to back
    send(2'b01, 1'b1, 1'b1, 16'd2, {4{16'd5}}, {$urandom, $urandom});
    for (int k = 0; k < 3; k++) send(2'b01, 1'b1, 1'b0, 16'd1, {4{16'd7}}, {$urandom, $urandom});
    idle(3);
    expect_lanes("acc_chain", {4{16'd31}});

    // Mixed: acc_clr without acc_en is ignored, acc stays at 31
    idle(1);
    send(2'b01, 1'b0, 1'b1, 16'd0, {$urandom, $urandom}, {4{16'd5}});
    idle(3);
    expect_lanes("mixed_ext", {4{16'd5}});
    send(2'b01, 1'b1, 1'b0, 16'd1, {4{16'd1}}, {$urandom, $urandom});
    idle(3);
    expect_lanes("mixed_acc", {4{16'd32}});

    // Reset mid-stream during beat 3
    for (int k = 0; k < 3; k++)
      send(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 16'($urandom),
           {$urandom, $urandom}, {$urandom, $urandom});
    #2;
    rstn = 1'b0;
    #1;
    check_val("rst_async_valid", {63'b0, out_valid}, 64'h0);
    check_val("rst_async_data", {mac_data_3, mac_data_2, mac_data_1, mac_data_0}, 64'h0);
    in_valid = 1'b0;
    n_in -= exp_q.size();
    exp_q.delete();
    last_exp = '0;
    for (int i = 0; i < 4; i++) acc_m[i] = '0;
    repeat (2) @(posedge clk);
    #3;
    rstn = 1'b1;
    send(2'b01, 1'b1, 1'b0, 16'd0, {$urandom, $urandom}, {$urandom, $urandom});
    idle(3);
    expect_lanes("rst_acc_zero", 64'h0);
    for (int k = 0; k < 3; k++)
      send(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 16'($urandom),
           {$urandom, $urandom}, {$urandom, $urandom});

    // Random soak
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      send(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 16'($urandom),
           {$urandom, $urandom}, {$urandom, $urandom});
    end
    idle(4);
    @(negedge clk);
    #1;
    check_val("queue_empty", 64'(exp_q.size()), 64'h0);
    check_val("beat_count", 64'(n_out), 64'(n_in));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mac_array.md
# mac_array

Four-lane multiply-accumulate datapath that sits on the far side of the AGU's MAC port. It consumes the AGU's `mac_A` (one 16-bit matrix element) and `mac_B`/`mac_C` (four packed 16-bit lanes). It returns four results modulo q on `mac_data_0..3` after a fixed two-cycle pipeline. An optional internal accumulator mode lets long inner-product loops run without round-tripping partial sums through RAM.

## Interface
Parameters:
- `LANES`, 4: number of 16-bit lanes. Fixed at 4; the parameter exists for documentation and assertions only.
- `W`, 16: lane width in bits.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rstn` input 1: reset, asynchronous and active-low.
- `mode` input [1:0]: FrodoKEM parameter set, same encoding as the AGU. 00 = Frodo-640 (q = 2^15); 01 = 976; 10 = 1344; 11 reserved. Every code other than 00 gives q = 2^16.
- `in_valid` input 1: the current beat of `mac_A/B/C` is valid.
- `acc_en` input 1: qualified by `in_valid`. The addend is the lane's internal accumulator instead of `mac_C`.
- `acc_clr` input 1: qualified by `in_valid` and `acc_en`. The addend is 0 for this beat, which starts a new sum.
- `mac_A` input [15:0]: scalar multiplicand, broadcast to all lanes.
- `mac_B` input [63:0]: lane i multiplicand is `mac_B[16i+15:16i]`.
- `mac_C` input [63:0]: lane i external addend, packed the same way as `mac_B`.
- `out_valid` output 1: `mac_data_*` hold a valid result this cycle.
- `mac_data_0..3` output [15:0] each: lane results.

## Operation
- Per lane i, the result is r_i = (A·B_i + addend_i) mod q.
  - addend_i is `mac_C` lane i when `acc_en` = 0.
  - addend_i is acc_i when `acc_en` = 1 and `acc_clr` = 0.
  - addend_i is 0 when `acc_en` = 1 and `acc_clr` = 1.
- Arithmetic:
  - Product: 16×16 unsigned, truncated to the low 16 bits. This is valid because q divides 2^16.
  - Sum: 16-bit wrap-around.
  - Final mask: when q = 2^15, bit 15 is forced to 0 on the result and on acc_i.
- `mode` is sampled with the beat at stage 1 and carried down the pipeline. Changing `mode` between beats is legal and affects only the later beats.
- Accumulator acc_i (16 bits per lane):
  - Updated to r_i on every stage-2 beat that has `acc_en` = 1.
  - Left unchanged by beats with `acc_en` = 0 and by idle cycles.
  - acc_i is read in stage 2, where it is written. Back-to-back `acc_en` beats therefore chain correctly with no hazard or stall.
- `acc_clr` without `acc_en` is ignored; `mac_C` is used.
- No backpressure. Every `in_valid` beat produces exactly one `out_valid` beat. The consumer (AGU) must always accept.

## Timing
- Stage 1, the registered input beat:
  - Registers lane products A·B_i[15:0], the `mac_C` lanes, and `acc_en`, `acc_clr`, q-select and valid.
- Stage 2:
  - Selects the addend, adds, masks, and registers `mac_data_*` and `out_valid`.
  - Writes acc_i in the same edge.
- Latency: a beat presented with `in_valid` at edge n appears with `out_valid` = 1 after edge n+2.
- Throughput is one beat per cycle, so a continuous `in_valid` train gives a continuous `out_valid` train.
- When `out_valid` = 0, `mac_data_*` hold their last value. Consumers must qualify them with `out_valid`.
- Reset, asserted at any time including mid-stream:
  - Immediately clears all pipeline valids, `out_valid`, `mac_data_0..3` (to 16'h0000) and every acc_i (to 0).
  - Beats in flight are dropped.
  - The first `in_valid` beat after `rstn` rises is handled normally.

## Structure
- Shared package `frodo_pkg`:
  - `mode` encodings: MODE_640, MODE_976, MODE_1344.
  - Lane width W = 16 and LANES = 4.
  - A function returning the q mask for a mode: 16'h7FFF or 16'hFFFF.
  - The AGU should import the same package.
- Sub-module `mac_lane`: one lane, holding its stage-1 product register, stage-2 adder and mask, and acc register. Instantiate it four times in `mac_array`. The valid and control pipeline is shared in `mac_array`.

## Test plan
- **Basic, 640:** mode=00, A=3, B lanes {1,2,3,4}, C lanes {10,20,30,40}, one beat → two cycles later `out_valid`=1 for exactly one cycle, data {13,26,39,52}.
- **Wrap, 640 vs 976:** A=16'h8001, B lane0=16'h0003, C lane0=16'h7FFF.
  - Raw value: 3·0x8001 = 0x18003 → 0x8003, and 0x8003 + 0x7FFF = 0x10002 → 0x0002.
  - mode=00 → lane0 = 16'h0002 (mask leaves it unchanged). mode=01 → lane0 = 16'h0002.
  - Second case: A=1, B=16'h8000, C=0 → mode=00 gives 16'h0000, mode=01 gives 16'h8000.
- **Accumulate chain:** mode=01. Beat 1: `acc_en`=1, `acc_clr`=1, A=2, B lanes all 5. Then 3 back-to-back beats with `acc_en`=1, `acc_clr`=0, A=1, B lanes all 7 → outputs 10, 17, 24, 31 on 4 consecutive cycles, and acc_i=31.
- **Mixed and idle:** after the chain, one idle cycle, then a beat with `acc_en`=0 (A=0, C=5) → output 5 and acc unchanged at 31. Next `acc_en` beat with A=1, B=1 → 32.
- **Reset mid-stream:** a 6-beat continuous train with `rstn` pulsed low during beat 3 → `out_valid` drops asynchronously, outputs and acc read 0, and no stale beats emerge after release. A new beat afterwards produces a correct result after 2 cycles.
- **Random soak:** 10k random beats with random mode, `acc_en` and `acc_clr`, checked against a reference model for data, `out_valid` count equal to `in_valid` count, and 2-cycle latency.
